// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl_pkg
//   Shared encodings for the multi-cycle MIPS-subset control unit: FSM state
//   codes, OpCode/Funct values, ALUOp codes, datapath mux selects and the
//   bundled control-word struct produced by the output decoder.
// ---------------------------------------------------------------------------
package mcpu_ctrl_pkg;

  // FSM states; codes are visible on state_dbg so they are pinned explicitly.
  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes that need special handling in the controller
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALUOp: [2:0] operation, [3] selects signed compare for SLT
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_FUNCT = 4'h2;
  localparam logic [3:0] ALU_AND   = 4'h3;
  localparam logic [3:0] ALU_OR    = 4'h4;
  localparam logic [3:0] ALU_SLTU  = 4'h5;
  localparam logic [3:0] ALU_SLTS  = 4'hD;

  // Register-file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register-file write data select
  localparam logic [1:0] WB_MDR    = 2'b00;
  localparam logic [1:0] WB_ALUOUT = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // Complete per-cycle control word driven towards the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // R-type functions the datapath implements
  function automatic logic is_valid_r_funct(input logic [5:0] funct);
    return (funct inside {[6'h20:6'h27], FN_SLT, FN_SLTU,
                          FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR});
  endfunction

  // Constant shifts take their first operand from the shamt field
  function automatic logic is_shift_funct(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//   Bundle between the control FSM and the multi-cycle datapath.
//   master : controller side (drives controls, reads IR fields + mem_ready)
//   slave  : datapath side (the reverse)
//   Signals: OpCode/Funct (IR fields), mem_ready (memory done), datapath
//   enables/selects, instr_done, illegal_instr, state_dbg.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ExtOp;
  logic       LuiOp;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ExtOp, LuiOp, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_instr, state_dbg
  );

  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ExtOp, LuiOp, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_instr, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_outdec.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl_outdec
//   Combinational Moore decode of the current FSM state (qualified by the
//   instruction fields, which are stable from ID onward) into the datapath
//   control word. mem_ready only qualifies IRWrite/PCWrite in IF and
//   instr_done in MEMWR.
//   Ports: i_state, i_opcode, i_funct, i_mem_ready -> o_ctrl
// ---------------------------------------------------------------------------
module mcpu_ctrl_outdec
  import mcpu_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_IF: begin
        // Fetch and PC+4 share the ALU; both commit only when memory delivers.
        o_ctrl.i_or_d    = 1'b0;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_a = SRCA_PC;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        o_ctrl.alu_src_a = SRCA_PC;
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.ext_op    = 1'b1;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = SRCA_A;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.ext_op    = 1'b1;
      end
      S_MEMRD: begin
        o_ctrl.i_or_d   = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_dst    = REGDST_RT;
        o_ctrl.mem_to_reg = WB_MDR;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe is held until the memory accepts it.
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_REX: begin
        o_ctrl.alu_src_a = is_shift_funct(i_funct) ? SRCA_SHAMT : SRCA_A;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_dst    = REGDST_RD;
        o_ctrl.mem_to_reg = WB_ALUOUT;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        // Zero flag of A-B gates the write of the ID-computed target.
        o_ctrl.alu_src_a     = SRCA_A;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_IEX: begin
        o_ctrl.alu_src_a = SRCA_A;
        o_ctrl.alu_src_b = SRCB_IMM;
        // Logical immediates are zero-extended.
        o_ctrl.ext_op    = !((i_opcode == OP_ANDI) || (i_opcode == OP_ORI));
        o_ctrl.lui_op    = (i_opcode == OP_LUI);
        case (i_opcode)
          OP_ANDI:  o_ctrl.alu_op = ALU_AND;
          OP_ORI:   o_ctrl.alu_op = ALU_OR;
          OP_SLTI:  o_ctrl.alu_op = ALU_SLTS;
          OP_SLTIU: o_ctrl.alu_op = ALU_SLTU;
          default:  o_ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_IWB: begin
        o_ctrl.reg_dst    = REGDST_RT;
        o_ctrl.mem_to_reg = WB_ALUOUT;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from IF, so the link value is written on the
        // same edge the PC moves to the jump target.
        o_ctrl.reg_dst    = REGDST_RA;
        o_ctrl.mem_to_reg = WB_PC;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_REG;
        o_ctrl.instr_done = 1'b1;
        if (i_funct == FN_JALR) begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = REGDST_RD;
          o_ctrl.mem_to_reg = WB_PC;
        end
      end
      default: begin
        // S_TRAP and unused codes: everything stays inactive.
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Main control FSM of the multi-cycle MIPS-subset CPU. Holds the state
//   register and the sticky illegal-instruction flag, computes the next
//   state from OpCode/Funct/mem_ready and drives the datapath controls
//   through mcpu_ctrl_outdec.
//   Ports: clk (rising edge), reset (async, active low),
//          bus (master modport: IR fields, mem_ready in; controls,
//          instr_done, illegal_instr, state_dbg out)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
  import mcpu_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  multicycle_ctrl_fsm_if.master      bus
);

  state_t r_state;
  state_t w_state_next;
  logic   r_illegal;
  logic   w_illegal_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_out;

  // State register and sticky trap flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IF;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_illegal_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IF:     w_state_next = bus.mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (bus.OpCode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE: begin
            if ((bus.Funct == FN_JR) || (bus.Funct == FN_JALR))
              w_state_next = S_JR;
            else if (is_valid_r_funct(bus.Funct))
              w_state_next = S_REX;
            else
              w_state_next = S_TRAP;
          end
          OP_BEQ:   w_state_next = S_BEQ;
          OP_J:     w_state_next = S_JUMP;
          OP_JAL:   w_state_next = S_JAL;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI:
                    w_state_next = S_IEX;
          default:  w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_state_next = (bus.OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_state_next = bus.mem_ready ? S_IF : S_MEMWR;
      S_REX:    w_state_next = S_RWB;
      S_IEX:    w_state_next = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BEQ, S_JUMP, S_JAL, S_JR:
                w_state_next = S_IF;
      S_TRAP:   w_state_next = S_TRAP;
      default:  w_state_next = S_IF;
    endcase
  end

  // Flag latches on the transition into TRAP and then holds until reset.
  assign w_illegal_next = r_illegal | (w_state_next == S_TRAP);

  mcpu_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_opcode    (bus.OpCode),
    .i_funct     (bus.Funct),
    .i_mem_ready (bus.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // While reset is held every control is forced inactive, including the
  // combinational IF decode that would otherwise assert MemRead.
  assign w_ctrl_out = reset ? w_ctrl : '0;

  assign bus.PCWrite       = w_ctrl_out.pc_write;
  assign bus.PCWriteCond   = w_ctrl_out.pc_write_cond;
  assign bus.IorD          = w_ctrl_out.i_or_d;
  assign bus.MemRead       = w_ctrl_out.mem_read;
  assign bus.MemWrite      = w_ctrl_out.mem_write;
  assign bus.IRWrite       = w_ctrl_out.ir_write;
  assign bus.RegWrite      = w_ctrl_out.reg_write;
  assign bus.ExtOp         = w_ctrl_out.ext_op;
  assign bus.LuiOp         = w_ctrl_out.lui_op;
  assign bus.RegDst        = w_ctrl_out.reg_dst;
  assign bus.MemtoReg      = w_ctrl_out.mem_to_reg;
  assign bus.ALUSrcA       = w_ctrl_out.alu_src_a;
  assign bus.ALUSrcB       = w_ctrl_out.alu_src_b;
  assign bus.ALUOp         = w_ctrl_out.alu_op;
  assign bus.PCSource      = w_ctrl_out.pc_source;
  assign bus.instr_done    = w_ctrl_out.instr_done;
  assign bus.illegal_instr = r_illegal;
  assign bus.state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Directed stimulus for the multi-cycle control FSM. Expected per-cycle
//   field values and expected instruction latencies are queued by the
//   stimulus; a separate monitor compares them on the falling clock edge.
//   F_EN packs {PCWrite,PCWriteCond,MemWrite,IRWrite,RegWrite,instr_done,
//   illegal_instr,MemRead}.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  int   start_cyc;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {F_STATE, F_EN, F_IORD, F_REGDST, F_MEMTOREG,
                    F_SRCA, F_SRCB, F_ALUOP, F_PCSRC, F_MISC} fld_e;

  typedef struct {
    string      name;
    int         cyc;
    fld_e       f;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   ret_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(input fld_e f);
    case (f)
      F_STATE:    return {4'b0, bus.state_dbg};
      F_EN:       return {bus.PCWrite, bus.PCWriteCond, bus.MemWrite, bus.IRWrite,
                          bus.RegWrite, bus.instr_done, bus.illegal_instr, bus.MemRead};
      F_IORD:     return {7'b0, bus.IorD};
      F_REGDST:   return {6'b0, bus.RegDst};
      F_MEMTOREG: return {6'b0, bus.MemtoReg};
      F_SRCA:     return {6'b0, bus.ALUSrcA};
      F_SRCB:     return {6'b0, bus.ALUSrcB};
      F_ALUOP:    return {4'b0, bus.ALUOp};
      F_PCSRC:    return {6'b0, bus.PCSource};
      default:    return {6'b0, bus.ExtOp, bus.LuiOp};
    endcase
  endfunction

  // Monitor: field scoreboard and retirement-latency scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] a;
    int lat;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s stale expectation cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        a = actual(e.f);
        if (a !== e.val) begin
          failures++;
          $display("FAIL %s field %s cycle %0d: got %h expected %h", e.name, e.f.name(), cyc, a, e.val);
        end else begin
          $display("ok   %s field %s cycle %0d = %h", e.name, e.f.name(), cyc, a);
        end
      end
    end
    if (!reset) begin
      start_cyc = cyc + 1;
    end else if (bus.instr_done === 1'b1) begin
      lat = cyc - start_cyc + 1;
      checks++;
      if (ret_q.size() == 0) begin
        failures++;
        $display("FAIL retire unexpected instr_done at cycle %0d (latency %0d)", cyc, lat);
      end else begin
        int want;
        want = ret_q.pop_front();
        if (lat != want) begin
          failures++;
          $display("FAIL retire latency at cycle %0d: got %0d expected %0d", cyc, lat, want);
        end else begin
          $display("ok   retire at cycle %0d latency %0d", cyc, lat);
        end
      end
      start_cyc = cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string n, input fld_e f, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.cyc  = cyc;
    e.f    = f;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic st(input string n, input logic [3:0] s, input logic [7:0] en);
    ex(n, F_STATE, {4'b0, s});
    ex(n, F_EN, en);
  endtask

  // IF (mem_ready=1) then ID for a new instruction; lat=0 means no retirement.
  task automatic fetch(input string n, input logic [5:0] op, input logic [5:0] fn, input int lat);
    tick();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.OpCode    = op;
    bus.Funct     = fn;
    st({n, "_if"}, 4'd0, 8'h91);
    if (lat > 0) ret_q.push_back(lat);
    tick();
    st({n, "_id"}, 4'd1, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; failures = 0; start_cyc = 0;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.OpCode = 6'h00;
    bus.Funct  = 6'h00;

    tick();                                  // held in reset
    st("rst_hold", 4'd0, 8'h00);

    // Release, IF waits two cycles for memory, then lw.
    tick(); reset = 1'b1; bus.OpCode = 6'h23;
    st("if_wait0", 4'd0, 8'h01); ex("if_wait0", F_IORD, 8'h00);
    ret_q.push_back(7);
    tick(); st("if_wait1", 4'd0, 8'h01);
    tick(); bus.mem_ready = 1'b1; st("if_ready", 4'd0, 8'h91);
    tick(); st("lw0_id", 4'd1, 8'h00); ex("lw0_id", F_SRCB, 8'h03); ex("lw0_id", F_MISC, 8'h02);
    tick(); st("lw0_madr", 4'd2, 8'h00); ex("lw0_madr", F_SRCA, 8'h01); ex("lw0_madr", F_SRCB, 8'h02);
    tick(); st("lw0_mrd", 4'd3, 8'h01); ex("lw0_mrd", F_IORD, 8'h01);
    tick(); st("lw0_mwb", 4'd4, 8'h0C); ex("lw0_mwb", F_MEMTOREG, 8'h00); ex("lw0_mwb", F_REGDST, 8'h00);

    // lw with memory always ready: 5 cycles
    fetch("lw1", 6'h23, 6'h00, 5);
    tick(); st("lw1_madr", 4'd2, 8'h00);
    tick(); st("lw1_mrd", 4'd3, 8'h01);
    tick(); st("lw1_mwb", 4'd4, 8'h0C);

    // Reset asserted mid-instruction in MEMRD while memory reports ready
    fetch("lw2", 6'h23, 6'h00, 0);
    tick(); st("lw2_madr", 4'd2, 8'h00);
    tick(); bus.mem_ready = 1'b0; st("lw2_mrd", 4'd3, 8'h01);
    tick(); bus.mem_ready = 1'b1; reset = 1'b0;
    st("rst_mid", 4'd0, 8'h00); ex("rst_mid", F_SRCB, 8'h00);
    tick(); st("rst_mid2", 4'd0, 8'h00);

    // beq: 3 cycles
    fetch("beq", 6'h04, 6'h00, 3);
    ex("beq_if", F_IORD, 8'h00);
    tick(); st("beq_ex", 4'd8, 8'h44); ex("beq_ex", F_PCSRC, 8'h01);
    ex("beq_ex", F_ALUOP, 8'h01); ex("beq_ex", F_SRCA, 8'h01); ex("beq_ex", F_SRCB, 8'h00);

    // jal: 3 cycles
    fetch("jal", 6'h03, 6'h00, 3);
    tick(); st("jal_ex", 4'd12, 8'h8C); ex("jal_ex", F_REGDST, 8'h02);
    ex("jal_ex", F_MEMTOREG, 8'h02); ex("jal_ex", F_PCSRC, 8'h02);

    // sltiu / slti
    fetch("sltiu", 6'h0B, 6'h00, 4);
    tick(); st("sltiu_ex", 4'd10, 8'h00); ex("sltiu_ex", F_ALUOP, 8'h05);
    ex("sltiu_ex", F_SRCA, 8'h01); ex("sltiu_ex", F_SRCB, 8'h02); ex("sltiu_ex", F_MISC, 8'h02);
    tick(); st("sltiu_wb", 4'd11, 8'h0C); ex("sltiu_wb", F_REGDST, 8'h00); ex("sltiu_wb", F_MEMTOREG, 8'h01);
    fetch("slti", 6'h0A, 6'h00, 4);
    tick(); st("slti_ex", 4'd10, 8'h00); ex("slti_ex", F_ALUOP, 8'h0D);
    tick(); st("slti_wb", 4'd11, 8'h0C);

    // sw with one write wait cycle: 5 cycles
    fetch("sw", 6'h2B, 6'h00, 5);
    tick(); st("sw_madr", 4'd2, 8'h00);
    tick(); bus.mem_ready = 1'b0; st("sw_wait", 4'd5, 8'h20); ex("sw_wait", F_IORD, 8'h01);
    tick(); bus.mem_ready = 1'b1; st("sw_done", 4'd5, 8'h24);

    // R-type: shift uses shamt, add uses A
    fetch("sra", 6'h00, 6'h03, 4);
    tick(); st("sra_ex", 4'd6, 8'h00); ex("sra_ex", F_SRCA, 8'h02);
    ex("sra_ex", F_ALUOP, 8'h02); ex("sra_ex", F_SRCB, 8'h00);
    tick(); st("sra_wb", 4'd7, 8'h0C); ex("sra_wb", F_REGDST, 8'h01); ex("sra_wb", F_MEMTOREG, 8'h01);
    fetch("add", 6'h00, 6'h20, 4);
    tick(); st("add_ex", 4'd6, 8'h00); ex("add_ex", F_SRCA, 8'h01);
    tick(); st("add_wb", 4'd7, 8'h0C);

    // jalr, jr, j
    fetch("jalr", 6'h00, 6'h09, 3);
    tick(); st("jalr_ex", 4'd13, 8'h8C); ex("jalr_ex", F_PCSRC, 8'h03);
    ex("jalr_ex", F_REGDST, 8'h01); ex("jalr_ex", F_MEMTOREG, 8'h02);
    fetch("jr", 6'h00, 6'h08, 3);
    tick(); st("jr_ex", 4'd13, 8'h84); ex("jr_ex", F_PCSRC, 8'h03);
    fetch("j", 6'h02, 6'h00, 3);
    tick(); st("j_ex", 4'd9, 8'h84); ex("j_ex", F_PCSRC, 8'h02);

    // andi (zero-extend), lui
    fetch("andi", 6'h0C, 6'h00, 4);
    tick(); st("andi_ex", 4'd10, 8'h00); ex("andi_ex", F_ALUOP, 8'h03); ex("andi_ex", F_MISC, 8'h00);
    tick(); st("andi_wb", 4'd11, 8'h0C);
    fetch("lui", 6'h0F, 6'h00, 4);
    tick(); st("lui_ex", 4'd10, 8'h00); ex("lui_ex", F_ALUOP, 8'h00); ex("lui_ex", F_MISC, 8'h03);
    tick(); st("lui_wb", 4'd11, 8'h0C);

    // Illegal R funct: absorbing TRAP for 20 cycles, memory toggling
    fetch("badfn", 6'h00, 6'h3F, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.mem_ready = i[0];
      st("trap_fn", 4'd14, 8'h02);
    end
    tick(); reset = 1'b0; st("trap_rst", 4'd0, 8'h00);
    tick(); st("trap_rst2", 4'd0, 8'h00);

    // Illegal opcode
    fetch("badop", 6'h3F, 6'h00, 0);
    tick(); st("trap_op", 4'd14, 8'h02);
    tick(); reset = 1'b0; st("trap_op_rst", 4'd0, 8'h00);

    // Normal operation resumes after reset
    fetch("addi", 6'h08, 6'h00, 4);
    tick(); st("addi_ex", 4'd10, 8'h00); ex("addi_ex", F_ALUOP, 8'h00); ex("addi_ex", F_MISC, 8'h02);
    tick(); st("addi_wb", 4'd11, 8'h0C);

    tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_queue: %0d expectations left, required 0", exp_q.size());
    end
    checks++;
    if (ret_q.size() != 0) begin
      failures++;
      $display("FAIL retire_queue: %0d retirements not seen, required 0", ret_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
